voice_allocator: RTL
====================

// Module: voice_allocator
// PURPOSE
//  Polyphony scheduler ahead of the per-voice ADSR-envelope + envelope-mixer chains. Accepts a
//  stream of note-on/note-off events and assigns each event to one of NUM_VOICES voices.
//  Drives each voice's note_on gate, note number and velocity. Steals the best candidate voice
//  when all voices are busy, and forces a gate-low gap so each envelope sees a clean retrigger edge.
// PARAMETERS
//  NUM_VOICES     8  voice slots; >=2
//  AGE_WIDTH      8  per-voice saturating age counter width
//  RETRIG_CYCLES  2  gate-low cycles inserted before re-raising a retriggered or stolen voice; >=1
// PORTS
//  clk             in   1             system clock (single clock domain)
//  rst_n           in   1             synchronous reset, active-low
//  evt_valid       in   1             event offered
//  evt_ready       out  1             event accepted when valid&ready
//  evt_note_on     in   1             1=note-on, 0=note-off
//  evt_note        in   7             MIDI note number
//  evt_velocity    in   7             velocity; note-on with velocity 0 is treated as note-off
//  voice_active    in   NUM_VOICES    per-voice envelope nonzero (release tail still sounding)
//  voice_gate      out  NUM_VOICES    per-voice note_on to the ADSR
//  voice_note      out  7*NUM_VOICES  voice i in bits [7i+6:7i]
//  voice_velocity  out  7*NUM_VOICES  same packing as voice_note
//  steal_pulse     out  1             1-cycle pulse when a sounding voice is stolen
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): all outputs 0, ages 0, FSM to IDLE. Reset mid-operation
//    abandons the event in flight; no partial commit.
//  - FSM states: IDLE -> SCAN -> COMMIT -> (RETRIG ->) IDLE. evt_ready=1 only in IDLE.
//    The event is latched on the accept edge.
//  - SCAN: one voice per cycle, index 0..NUM_VOICES-1, keeping a running best candidate;
//    lasts NUM_VOICES cycles.
//  - Note-on selection priority:
//    (1) gated voice with same note -> retrigger;
//    (2) free voice (gate=0 & active=0), lowest index;
//    (3) releasing voice (gate=0 & active=1), max age, ties to lowest index;
//    (4) gated voice, max age, ties to lowest index -> steal.
//  - COMMIT, note-on: write note/velocity, zero the chosen voice's age, and increment the other
//    voices' ages (saturating at 2^AGE_WIDTH-1).
//    - Cases (2)/(3): gate=1 at COMMIT; back to IDLE.
//    - Cases (1)/(4): gate=0 for RETRIG_CYCLES in RETRIG, then gate=1 on RETRIG exit.
//      steal_pulse asserts in COMMIT for case (4) only.
//  - COMMIT, note-off: clear the gate of the lowest-index gated voice holding that note.
//    No match: event dropped silently. Note/velocity fields are retained for the release tail.
//  - Latency from accept to gate change: NUM_VOICES+1 cycles; retrigger or steal adds
//    RETRIG_CYCLES.
//  - Back-to-back events: the next one is accepted no earlier than the cycle after the FSM
//    returns to IDLE.
//  - voice_active is sampled during SCAN only; changes after a voice has been scanned do not
//    affect the current event.
// CONFIGURATION
//  SUSTAIN_PEDAL_EN defined:
//  - Adds input sustain_pedal (1 bit) and a per-voice sustained flag.
//  - A note-off matching while the pedal is 1 sets the flag instead of clearing the gate.
//  - Pedal falling edge (registered) clears the gate of every flagged voice in one cycle,
//    and clears the flags.
//  - Selection treats flagged voices as gated. Matching note-on on a flagged voice clears its
//    flag and retriggers.
//  SUSTAIN_PEDAL_EN undefined: no port, no flags; behaviour exactly as above.
// STRUCTURE
//  synth_pkg:
//  - NOTE_W=7, VEL_W=7.
//  - FSM state encoding ST_IDLE/ST_SCAN/ST_COMMIT/ST_RETRIG.
//  - Candidate class codes CLS_NONE/CLS_SAME/CLS_FREE/CLS_REL/CLS_STEAL.
//  Sub-module voice_candidate_cmp (combinational):
//  - Compares the current best (class, age, index) against the scanned voice.
//  - Returns the new best per the priority rules.
// TESTING
//  1. Reset, then 8 note-ons notes 60..67, vel 100: voices 0..7 gated in order, note fields
//     60..67, steal_pulse never.
//  2. Note-off 62: voice 2 gate->0 at accept+9; note-on 70 with voice_active[2]=1 and all others
//     gated -> voice 2 reused (case 3), no steal_pulse.
//  3. All 8 gated, none releasing, note-on 72: voice 0 (oldest, age 7) stolen.
//     steal_pulse=1 one cycle; gate0 low 2 cycles, then high; voice_note[6:0]=72.
//  4. Note-on 60 while voice 0 holds 60 gated: same voice retriggered, gate low 2 cycles.
//     Note-on 64 vel 0: acts as note-off. Note-off 99 (unmatched): no output change.
//  5. Hold evt_valid continuously: evt_ready only in IDLE, one event per 10/12 cycles.
//     rst_n=0 during SCAN: all gates 0 next cycle, FSM IDLE.
//  6. SUSTAIN_PEDAL_EN: pedal=1, note-off 60 -> gate stays 1; pedal 1->0 -> gate0 falls
//     one cycle after the registered edge.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared widths, FSM encoding and candidate class codes for the polyphony voice allocator.
package synth_pkg;

  localparam int unsigned NOTE_W = 7;
  localparam int unsigned VEL_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RETRIG = 2'd3
  } state_e;

  // Numeric order equals selection priority (higher code wins)
  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_STEAL = 3'd1,
    CLS_REL   = 3'd2,
    CLS_FREE  = 3'd3,
    CLS_SAME  = 3'd4
  } cls_e;

  // Releasing and stealable voices break ties by age; the others keep the lowest index
  function automatic logic cls_uses_age(input cls_e c);
    return (c == CLS_REL) || (c == CLS_STEAL);
  endfunction

endpackage

// File: rtl/voice_candidate_cmp.sv
// Combinational best-candidate update: compares the running best against one scanned voice.
module voice_candidate_cmp
  import synth_pkg::*;
#(
  parameter int unsigned AGE_WIDTH = 8,
  parameter int unsigned IDX_W     = 3
) (
  input  cls_e                 i_best_cls,
  input  logic [AGE_WIDTH-1:0] i_best_age,
  input  logic [IDX_W-1:0]     i_best_idx,
  input  logic [NOTE_W-1:0]    i_evt_note,
  input  logic                 i_cand_gate,
  input  logic                 i_cand_active,
  input  logic [NOTE_W-1:0]    i_cand_note,
  input  logic [AGE_WIDTH-1:0] i_cand_age,
  input  logic [IDX_W-1:0]     i_cand_idx,
  output cls_e                 o_best_cls,
  output logic [AGE_WIDTH-1:0] o_best_age,
  output logic [IDX_W-1:0]     o_best_idx
);

  cls_e w_cand_cls;
  logic w_take;

  // Classify the scanned voice and keep whichever of best/candidate ranks higher
  always_comb begin
    w_cand_cls = CLS_STEAL;
    w_take     = 1'b0;
    o_best_cls = i_best_cls;
    o_best_age = i_best_age;
    o_best_idx = i_best_idx;

    if (i_cand_gate && (i_cand_note == i_evt_note)) begin
      w_cand_cls = CLS_SAME;
    end else if (!i_cand_gate && !i_cand_active) begin
      w_cand_cls = CLS_FREE;
    end else if (!i_cand_gate) begin
      w_cand_cls = CLS_REL;
    end

    if (w_cand_cls > i_best_cls) begin
      w_take = 1'b1;
    end else if ((w_cand_cls == i_best_cls) && cls_uses_age(w_cand_cls) &&
                 (i_cand_age > i_best_age)) begin
      w_take = 1'b1;
    end

    if (w_take) begin
      o_best_cls = w_cand_cls;
      o_best_age = i_cand_age;
      o_best_idx = i_cand_idx;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: assigns note-on/note-off events to voices, steals when full and
// inserts a gate-low gap on retrigger/steal. Optional sustain pedal via SUSTAIN_PEDAL_EN.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES    = 8,
  parameter int unsigned AGE_WIDTH     = 8,
  parameter int unsigned RETRIG_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         evt_valid,
  output logic                         evt_ready,
  input  logic                         evt_note_on,
  input  logic [NOTE_W-1:0]            evt_note,
  input  logic [VEL_W-1:0]             evt_velocity,
  input  logic [NUM_VOICES-1:0]        voice_active,
`ifdef SUSTAIN_PEDAL_EN
  input  logic                         sustain_pedal,
`endif
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [VEL_W*NUM_VOICES-1:0]  voice_velocity,
  output logic                         steal_pulse
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned RT_W  = $clog2(RETRIG_CYCLES + 1);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = {AGE_WIDTH{1'b1}};

  state_e               r_state;
  logic [IDX_W-1:0]     r_scan_idx;
  cls_e                 r_best_cls;
  logic [AGE_WIDTH-1:0] r_best_age;
  logic [IDX_W-1:0]     r_best_idx;
  logic                 r_evt_on;
  logic [NOTE_W-1:0]    r_evt_note;
  logic [VEL_W-1:0]     r_evt_vel;
  logic [RT_W-1:0]      r_retrig_cnt;
  logic [AGE_WIDTH-1:0] r_age [NUM_VOICES];

  logic                 w_cand_gate;
  logic                 w_cand_active;
  logic [NOTE_W-1:0]    w_cand_note;
  logic [AGE_WIDTH-1:0] w_cand_age;
  cls_e                 w_new_cls;
  logic [AGE_WIDTH-1:0] w_new_age;
  logic [IDX_W-1:0]     w_new_idx;

`ifdef SUSTAIN_PEDAL_EN
  logic [NUM_VOICES-1:0] r_sustain;
  logic                  r_pedal_q;
  logic                  r_pedal_d2;
  logic                  w_pedal_fall;

  assign w_pedal_fall = r_pedal_d2 & ~r_pedal_q;
`endif

  // Mux out the fields of the voice currently being scanned
  always_comb begin
    w_cand_gate   = 1'b0;
    w_cand_active = 1'b0;
    w_cand_note   = '0;
    w_cand_age    = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (IDX_W'(i) == r_scan_idx) begin
`ifdef SUSTAIN_PEDAL_EN
        w_cand_gate = voice_gate[i] | r_sustain[i];
`else
        w_cand_gate = voice_gate[i];
`endif
        w_cand_active = voice_active[i];
        w_cand_note   = voice_note[i*NOTE_W +: NOTE_W];
        w_cand_age    = r_age[i];
      end
    end
  end

  voice_candidate_cmp #(
    .AGE_WIDTH (AGE_WIDTH),
    .IDX_W     (IDX_W)
  ) u_cmp (
    .i_best_cls    (r_best_cls),
    .i_best_age    (r_best_age),
    .i_best_idx    (r_best_idx),
    .i_evt_note    (r_evt_note),
    .i_cand_gate   (w_cand_gate),
    .i_cand_active (w_cand_active),
    .i_cand_note   (w_cand_note),
    .i_cand_age    (w_cand_age),
    .i_cand_idx    (r_scan_idx),
    .o_best_cls    (w_new_cls),
    .o_best_age    (w_new_age),
    .o_best_idx    (w_new_idx)
  );

`ifdef SUSTAIN_PEDAL_EN
  // Two-stage pedal register; the falling edge is taken between the stages
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pedal_q  <= 1'b0;
      r_pedal_d2 <= 1'b0;
    end else begin
      r_pedal_q  <= sustain_pedal;
      r_pedal_d2 <= r_pedal_q;
    end
  end
`endif

  // Event FSM: accept, scan all voices, commit the decision, optional retrigger gap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_scan_idx     <= '0;
      r_best_cls     <= CLS_NONE;
      r_best_age     <= '0;
      r_best_idx     <= '0;
      r_evt_on       <= 1'b0;
      r_evt_note     <= '0;
      r_evt_vel      <= '0;
      r_retrig_cnt   <= '0;
      evt_ready      <= 1'b0;
      voice_gate     <= '0;
      voice_note     <= '0;
      voice_velocity <= '0;
      steal_pulse    <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) r_age[i] <= '0;
`ifdef SUSTAIN_PEDAL_EN
      r_sustain      <= '0;
`endif
    end else begin
      steal_pulse <= 1'b0;

`ifdef SUSTAIN_PEDAL_EN
      // Pedal release drops every held voice; a same-cycle commit below takes precedence
      if (w_pedal_fall) begin
        voice_gate <= voice_gate & ~r_sustain;
        r_sustain  <= '0;
      end
`endif

      case (r_state)
        ST_IDLE: begin
          if (evt_valid && evt_ready) begin
            evt_ready  <= 1'b0;
            r_evt_on   <= evt_note_on && (evt_velocity != '0);
            r_evt_note <= evt_note;
            r_evt_vel  <= evt_velocity;
            r_scan_idx <= '0;
            r_best_cls <= CLS_NONE;
            r_best_age <= '0;
            r_best_idx <= '0;
            r_state    <= ST_SCAN;
          end else begin
            evt_ready <= 1'b1;
          end
        end

        ST_SCAN: begin
          r_best_cls <= w_new_cls;
          r_best_age <= w_new_age;
          r_best_idx <= w_new_idx;
          if (r_scan_idx == IDX_W'(NUM_VOICES - 1)) begin
            r_state <= ST_COMMIT;
          end else begin
            r_scan_idx <= r_scan_idx + IDX_W'(1);
          end
        end

        ST_COMMIT: begin
          if (r_evt_on) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (IDX_W'(i) == r_best_idx) begin
                r_age[i] <= '0;
                voice_note[i*NOTE_W +: NOTE_W]   <= r_evt_note;
                voice_velocity[i*VEL_W +: VEL_W] <= r_evt_vel;
`ifdef SUSTAIN_PEDAL_EN
                r_sustain[i] <= 1'b0;
`endif
                if ((r_best_cls == CLS_SAME) || (r_best_cls == CLS_STEAL)) begin
                  voice_gate[i] <= 1'b0;
                end else begin
                  voice_gate[i] <= 1'b1;
                end
              end else if (r_age[i] != AGE_MAX) begin
                r_age[i] <= r_age[i] + AGE_WIDTH'(1);
              end
            end
            if ((r_best_cls == CLS_SAME) || (r_best_cls == CLS_STEAL)) begin
              steal_pulse  <= (r_best_cls == CLS_STEAL);
              r_retrig_cnt <= RT_W'(RETRIG_CYCLES - 1);
              r_state      <= ST_RETRIG;
            end else begin
              evt_ready <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end else begin
            // Note-off: only a gated voice holding the note qualifies; otherwise dropped
            if (r_best_cls == CLS_SAME) begin
              for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == r_best_idx) begin
`ifdef SUSTAIN_PEDAL_EN
                  if (r_pedal_q) begin
                    r_sustain[i] <= 1'b1;
                  end else begin
                    voice_gate[i] <= 1'b0;
                  end
`else
                  voice_gate[i] <= 1'b0;
`endif
                end
              end
            end
            evt_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        ST_RETRIG: begin
          if (r_retrig_cnt == '0) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (IDX_W'(i) == r_best_idx) voice_gate[i] <= 1'b1;
            end
            evt_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_retrig_cnt <= r_retrig_cnt - RT_W'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
